// File: rtl/chip_intf_pkg.sv
// Shared definitions for the chip interface credit arbiter: channel tags, header
// length field bounds, FSM state type and channel count.
package chip_intf_pkg;

  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned FLIT_W     = 32;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned STAT_W     = 32;
  localparam int unsigned HDR_LEN_HI = 29;
  localparam int unsigned HDR_LEN_LO = 22;

  typedef logic [1:0] ch_tag_t;

  localparam ch_tag_t CH_IDLE = 2'b00;
  localparam ch_tag_t CH_NOC1 = 2'b01;
  localparam ch_tag_t CH_NOC2 = 2'b10;
  localparam ch_tag_t CH_NOC3 = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_t;

  // Channel index 0..2 maps to tag NOC1..NOC3.
  function automatic ch_tag_t idx_to_tag(input logic [1:0] idx);
    return ch_tag_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/chip_intf_credit_cnt.sv
// Per-channel credit counter: starts full, decrements per flit sent, increments per
// credit returned, saturates at CREDITS and flags an overflow stickily.
module chip_intf_credit_cnt #(
  parameter int unsigned CREDITS = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_dec,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDITS);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // A send and a return in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= MAX_CNT;
      r_err <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt == MAX_CNT) begin
        r_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_err = r_err;

endmodule

// File: rtl/chip_intf_credit_arb.sv
// Three-channel packet-atomic round-robin arbiter onto one credited off-chip flit port.
// Define CHIP_INTF_ARB_STATS_EN to add the saturating stall_cnt statistics port.
module chip_intf_credit_arb
  import chip_intf_pkg::*;
#(
  parameter int unsigned CREDITS = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        noc_valid,
  input  logic [NUM_CH*FLIT_W-1:0] noc_data,
  output logic [NUM_CH-1:0]        noc_ready,
  output logic [FLIT_W-1:0]        intf_data,
  output logic [1:0]               intf_channel,
  input  logic [NUM_CH-1:0]        intf_credit_back,
  output logic                     credit_err
`ifdef CHIP_INTF_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]        stall_cnt
`endif
);

  logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_CH-1:0]            w_cnt_err;
  logic [NUM_CH-1:0]            w_elig;
  logic [NUM_CH-1:0]            w_ready;
  logic [FLIT_W-1:0]            w_flit [NUM_CH];
  logic [1:0]                   w_idx;
  logic [1:0]                   w_pick;
  logic                         w_pick_vld;
  logic                         w_acc;
  logic [1:0]                   w_ch;
  logic [FLIT_W-1:0]            w_acc_flit;
  logic [LEN_W-1:0]             w_hdr_len;

  arb_state_t                   r_state;
  logic [1:0]                   r_ptr;
  logic [1:0]                   r_grant;
  logic [LEN_W-1:0]             r_remain;
  logic [FLIT_W-1:0]            r_data;
  ch_tag_t                      r_channel;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_flit[gi]   = noc_data[gi*FLIT_W +: FLIT_W];
    assign w_elig[gi]   = noc_valid[gi] && (w_cnt[gi] != '0);

    chip_intf_credit_cnt #(
      .CREDITS (CREDITS),
      .CNT_W   (CNT_W)
    ) u_credit_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_dec (w_ready[gi]),
      .i_inc (intf_credit_back[gi]),
      .o_cnt (w_cnt[gi]),
      .o_err (w_cnt_err[gi])
    );
  end

  // Round-robin search starting at the channel after the last granted one.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_idx      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_idx = 2'((32'(r_ptr) + k) % NUM_CH);
      if (!w_pick_vld && w_elig[w_idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_idx;
      end
    end
  end

  // Mid-packet only the owning channel may proceed; others wait for packet end.
  always_comb begin
    w_ready = '0;
    if (!rst) begin
      if (r_state == ST_IDLE) begin
        if (w_pick_vld) w_ready[w_pick] = 1'b1;
      end else if (w_elig[r_grant]) begin
        w_ready[r_grant] = 1'b1;
      end
    end
  end

  assign w_acc      = |w_ready;
  assign w_ch       = (r_state == ST_IDLE) ? w_pick : r_grant;
  assign w_acc_flit = w_flit[w_ch];
  assign w_hdr_len  = w_acc_flit[HDR_LEN_HI:HDR_LEN_LO];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'(NUM_CH - 1);
      r_grant   <= '0;
      r_remain  <= '0;
      r_data    <= '0;
      r_channel <= CH_IDLE;
    end else begin
      r_channel <= CH_IDLE;
      if (w_acc) begin
        r_data    <= w_acc_flit;
        r_channel <= idx_to_tag(w_ch);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_ptr <= w_pick;
            if (w_hdr_len != '0) begin
              r_state  <= ST_SEND;
              r_grant  <= w_pick;
              r_remain <= w_hdr_len;
            end
          end
        end
        ST_SEND: begin
          if (w_acc) begin
            r_remain <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign noc_ready    = w_ready;
  assign intf_data    = r_data;
  assign intf_channel = r_channel;
  assign credit_err   = |w_cnt_err;

`ifdef CHIP_INTF_ARB_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt;

  // Cycles with pending traffic but nothing sent; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((|noc_valid) && !w_acc && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_chip_intf_credit_arb.sv
// Self-checking bench for chip_intf_credit_arb: directed scenarios plus randomized
// traffic against a packet-level reference model.
module tb_chip_intf_credit_arb;

  localparam int CREDITS = 8;
  localparam int CNT_W   = 8;

  logic        clk;
  logic        rst;
  logic [2:0]  noc_valid;
  logic [95:0] noc_data;
  logic [2:0]  noc_ready;
  logic [31:0] intf_data;
  logic [1:0]  intf_channel;
  logic [2:0]  intf_credit_back;
  logic        credit_err;
`ifdef CHIP_INTF_ARB_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  chip_intf_credit_arb #(.CREDITS(CREDITS), .CNT_W(CNT_W)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .noc_valid        (noc_valid),
    .noc_data         (noc_data),
    .noc_ready        (noc_ready),
    .intf_data        (intf_data),
    .intf_channel     (intf_channel),
    .intf_credit_back (intf_credit_back),
    .credit_err       (credit_err)
`ifdef CHIP_INTF_ARB_STATS_EN
    ,
    .stall_cnt        (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: packet ownership, per-channel credits, last winner
  int          m_cred [3];
  int          m_owner;
  int          m_remain;
  int          m_last;
  bit          m_err;
  int          m_stall;
  logic [31:0] m_data;
  logic [1:0]  exp_ch;
  logic [2:0]  exp_ready;
  logic [2:0]  obs_ready;

  function automatic logic [31:0] hdr(input int len, input int tag);
    return {2'b00, 8'(len), 22'(tag)};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) m_cred[c] = CREDITS;
    m_owner = -1; m_remain = 0; m_last = 2; m_err = 1'b0; m_stall = 0;
    m_data = '0; exp_ch = 2'b00; exp_ready = 3'b000;
  endtask

  task automatic model_cycle(input logic [2:0] v, input logic [95:0] d, input logic [2:0] cb);
    int acc;
    logic [31:0] f;
    if (rst) begin
      model_reset();
      return;
    end
    acc = -1;
    if (m_owner >= 0) begin
      if (v[m_owner] && m_cred[m_owner] > 0) acc = m_owner;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        int c = (m_last + k) % 3;
        if (acc < 0 && v[c] && m_cred[c] > 0) acc = c;
      end
    end
    exp_ready = 3'b000;
    exp_ch    = 2'b00;
    if (acc >= 0) begin
      f = d[32*acc +: 32];
      exp_ready[acc] = 1'b1;
      exp_ch = 2'(acc + 1);
      m_data = f;
      if (m_owner < 0) begin
        m_last = acc;
        if (int'(f[29:22]) > 0) begin
          m_owner  = acc;
          m_remain = int'(f[29:22]);
        end
      end else begin
        m_remain--;
        if (m_remain == 0) m_owner = -1;
      end
    end else if (v != 3'b000) begin
      m_stall++;
    end
    for (int c = 0; c < 3; c++) begin
      if (cb[c] && acc != c) begin
        if (m_cred[c] == CREDITS) m_err = 1'b1;
        else m_cred[c]++;
      end else if (acc == c && !cb[c]) begin
        m_cred[c]--;
      end
    end
  endtask

  // One clock: drive inputs at negedge, capture noc_ready, step model, end past posedge.
  task automatic drive_cycle(input logic [2:0] v, input logic [95:0] d, input logic [2:0] cb);
    @(negedge clk);
    noc_valid = v;
    noc_data = d;
    intf_credit_back = cb;
    #1;
    obs_ready = noc_ready;
    model_cycle(v, d, cb);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_cycle(3'b000, '0, 3'b000);
    drive_cycle(3'b000, '0, 3'b000);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_cycle(3'b111, {hdr(0, 3), hdr(0, 2), hdr(0, 1)}, 3'b000);
    checks++; if (obs_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", obs_ready); end
    drive_cycle(3'b111, {hdr(0, 3), hdr(0, 2), hdr(0, 1)}, 3'b111);
    checks++; if (intf_channel !== 2'b00) begin errors++; $display("FAIL reset_channel: got %b want 00", intf_channel); end
    checks++; if (intf_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", intf_data); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err: got %b want 0", credit_err); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (u_dut.w_cnt[c] !== 8'(m_cred[c])) begin errors++; $display("FAIL reset_credits ch%0d: got %0d want %0d", c, u_dut.w_cnt[c], m_cred[c]); end
    end
`ifdef CHIP_INTF_ARB_STATS_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single_header();
    do_reset();
    drive_cycle(3'b010, 96'h0, 3'b000);
    checks++; if (obs_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b want 010", obs_ready); end
    checks++; if (intf_channel !== 2'b10) begin errors++; $display("FAIL single_channel: got %b want 10", intf_channel); end
    checks++; if (intf_data !== 32'h0) begin errors++; $display("FAIL single_data: got %h want 0", intf_data); end
    checks++; if (u_dut.w_cnt[1] !== 8'd7) begin errors++; $display("FAIL single_credit: got %0d want 7", u_dut.w_cnt[1]); end
    drive_cycle(3'b000, 96'h0, 3'b000);
    checks++; if (intf_channel !== 2'b00) begin errors++; $display("FAIL single_idle: got %b want 00", intf_channel); end
  endtask

  task automatic test_rr_order();
    logic [1:0]  order [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    int          idx [3] = '{0, 0, 0};
    logic [2:0]  v;
    logic [95:0] d;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 3; c++) begin
        v[c] = (idx[c] < 2);
        d[32*c +: 32] = (idx[c] == 0) ? hdr(1, 16 * c + i) : $urandom;
      end
      drive_cycle(v, d, 3'b000);
      checks++; if (intf_channel !== order[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, intf_channel, order[i]); end
      checks++; if (intf_data !== m_data) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, intf_data, m_data); end
      for (int c = 0; c < 3; c++) if (exp_ready[c]) idx[c]++;
    end
  endtask

  task automatic test_credit_stall();
    int sent = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_cycle(3'b001, {64'h0, hdr(0, 100 + sent)}, 3'b000);
      checks++;
      if (intf_channel !== ((i < 8) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL stall_channel[%0d]: got %b want %b", i, intf_channel, (i < 8) ? 2'b01 : 2'b00); end
      if (i < 8) begin
        checks++; if (intf_data !== hdr(0, 100 + i)) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, intf_data, hdr(0, 100 + i)); end
      end
      if (exp_ready[0]) sent++;
    end
    drive_cycle(3'b001, {64'h0, hdr(0, 100 + sent)}, 3'b001);
    checks++; if (obs_ready !== 3'b000) begin errors++; $display("FAIL stall_pulse_ready: got %b want 000", obs_ready); end
    checks++; if (intf_channel !== 2'b00) begin errors++; $display("FAIL stall_pulse_channel: got %b want 00", intf_channel); end
    drive_cycle(3'b001, {64'h0, hdr(0, 100 + sent)}, 3'b000);
    checks++; if (obs_ready !== 3'b001) begin errors++; $display("FAIL stall_resume_ready: got %b want 001", obs_ready); end
    checks++; if (intf_channel !== 2'b01) begin errors++; $display("FAIL stall_resume_channel: got %b want 01", intf_channel); end
    checks++; if (intf_data !== hdr(0, 108)) begin errors++; $display("FAIL stall_resume_data: got %h want %h", intf_data, hdr(0, 108)); end
`ifdef CHIP_INTF_ARB_STATS_EN
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
`endif
  endtask

  task automatic test_packet_atomic();
    logic [2:0]  vs [7] = '{3'b100, 3'b111, 3'b011, 3'b011, 3'b111, 3'b111, 3'b011};
    logic [1:0]  want [7] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3, 2'd1};
    logic [31:0] p3 [4];
    int          n3 = 0;
    do_reset();
    p3[0] = hdr(3, 7);
    for (int j = 1; j < 4; j++) p3[j] = $urandom;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(vs[i], {p3[(n3 < 4) ? n3 : 3], hdr(0, 22), hdr(0, 11)}, 3'b000);
      checks++; if (intf_channel !== want[i]) begin errors++; $display("FAIL atomic_channel[%0d]: got %0d want %0d", i, intf_channel, want[i]); end
      checks++; if (intf_data !== m_data) begin errors++; $display("FAIL atomic_data[%0d]: got %h want %h", i, intf_data, m_data); end
      if (exp_ready[2]) n3++;
    end
  endtask

  task automatic test_credit_err();
    do_reset();
    drive_cycle(3'b000, '0, 3'b010);
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", credit_err); end
    checks++; if (u_dut.w_cnt[1] !== 8'd8) begin errors++; $display("FAIL err_hold_count: got %0d want 8", u_dut.w_cnt[1]); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(3'b000, '0, 3'b000);
      checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d]: got %b want 1", i, credit_err); end
    end
    drive_cycle(3'b010, {32'h0, hdr(0, 5), 32'h0}, 3'b000);
    checks++; if (u_dut.w_cnt[1] !== 8'd7) begin errors++; $display("FAIL err_send_count: got %0d want 7", u_dut.w_cnt[1]); end
    drive_cycle(3'b010, {32'h0, hdr(0, 6), 32'h0}, 3'b010);
    checks++; if (u_dut.w_cnt[1] !== 8'd7) begin errors++; $display("FAIL err_simul_count: got %0d want 7", u_dut.w_cnt[1]); end
    checks++; if (intf_channel !== 2'b10) begin errors++; $display("FAIL err_simul_channel: got %b want 10", intf_channel); end
  endtask

  task automatic test_random();
    logic [2:0]  v;
    logic [2:0]  cb;
    logic [95:0] d;
    logic [31:0] f;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = 3'($urandom_range(0, 7));
      for (int c = 0; c < 3; c++) begin
        f = $urandom;
        f[29:22] = 8'($urandom_range(0, 3));
        d[32*c +: 32] = f;
        cb[c] = (m_cred[c] < CREDITS) && ($urandom_range(0, 2) == 0);
      end
      drive_cycle(v, d, cb);
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); end
      checks++; if (intf_channel !== exp_ch) begin errors++; $display("FAIL rand_channel[%0d]: got %b want %b", i, intf_channel, exp_ch); end
      checks++; if (intf_data !== m_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, intf_data, m_data); end
      checks++; if (credit_err !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", i, credit_err, m_err); end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (u_dut.w_cnt[c] !== 8'(m_cred[c])) begin errors++; $display("FAIL rand_credit[%0d] ch%0d: got %0d want %0d", i, c, u_dut.w_cnt[c], m_cred[c]); end
      end
    end
`ifdef CHIP_INTF_ARB_STATS_EN
    checks++; if (stall_cnt !== 32'(m_stall)) begin errors++; $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt, m_stall); end
`endif
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive_cycle(3'b001, {64'h0, hdr(5, 1)}, 3'b000);
    drive_cycle(3'b001, {64'h0, 32'hA5A5_0001}, 3'b000);
    checks++; if (intf_channel !== 2'b01) begin errors++; $display("FAIL midrst_pre_channel: got %b want 01", intf_channel); end
    rst = 1'b1;
    drive_cycle(3'b001, {64'h0, 32'hA5A5_0002}, 3'b000);
    rst = 1'b0;
    checks++; if (obs_ready !== 3'b000) begin errors++; $display("FAIL midrst_ready: got %b want 000", obs_ready); end
    checks++; if (intf_channel !== 2'b00) begin errors++; $display("FAIL midrst_channel: got %b want 00", intf_channel); end
    checks++; if (intf_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", intf_data); end
    checks++; if (u_dut.w_cnt[0] !== 8'd8) begin errors++; $display("FAIL midrst_credit: got %0d want 8", u_dut.w_cnt[0]); end
`ifdef CHIP_INTF_ARB_STATS_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL midrst_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    drive_cycle(3'b010, {32'h0, hdr(0, 2), 32'h0}, 3'b000);
    checks++; if (intf_channel !== 2'b10) begin errors++; $display("FAIL midrst_after_channel: got %b want 10", intf_channel); end
  endtask

  initial begin
    rst = 1'b1;
    noc_valid = 3'b000;
    noc_data = '0;
    intf_credit_back = 3'b000;
    obs_ready = 3'b000;
    model_reset();
    test_reset();
    test_single_header();
    test_rr_order();
    test_credit_stall();
    test_packet_atomic();
    test_credit_err();
    test_random();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/chip_intf_credit_arb.md
CHIP_INTF_CREDIT_ARB -- requirements
Module: chip_intf_credit_arb

Interface
REQ-001 Parameter CREDITS, default 8: per-channel credit depth at the off-chip receiver; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: credit counter width; SHALL satisfy CNT_W >= clog2(CREDITS+1).
REQ-003 clk  in  1: single clock; one clock, reset is synchronous and active-high.
REQ-004 rst  in  1: synchronous active-high reset.
REQ-005 noc_valid  in  3: per-channel flit valid; bit i is NoC(i+1).
REQ-006 noc_data  in  96: per-channel 32-bit flit; channel i occupies bits [32i+31:32i].
REQ-007 noc_ready  out  3: per-channel flit accepted this cycle.
REQ-008 intf_data  out  32: registered outbound flit.
REQ-009 intf_channel  out  2: registered channel tag; 2'b00 idle, 2'b01/10/11 NoC1/2/3.
REQ-010 intf_credit_back  in  3: one-cycle pulse per credit returned for the channel.
REQ-011 credit_err  out  1: sticky credit-overflow flag.
REQ-012 stall_cnt  out  32: present only with CHIP_INTF_ARB_STATS_EN.

Function
REQ-013 Each channel SHALL keep a credit counter, reset to CREDITS, decremented on every flit sent and incremented on every intf_credit_back pulse.
REQ-014 Simultaneous send and credit return on the same channel SHALL leave the counter unchanged.
REQ-015 An increment at CREDITS SHALL hold the count at CREDITS and set credit_err until rst.
REQ-016 A channel is eligible when noc_valid is 1 and its credit count is nonzero.
REQ-017 FSM states: IDLE, SEND.
REQ-018 In IDLE, an eligible channel is granted by round-robin, starting after the last granted channel; the pointer resets to NoC3, so NoC1 wins first.
REQ-019 The first accepted flit of a grant is the header; payload length = header bits [29:22].
REQ-020 Header with length 0: the packet completes in one flit, FSM stays in IDLE, and the pointer advances.
REQ-021 Header with length >0: FSM goes to SEND and a remaining-flit counter loads with the length.
REQ-022 In SEND, only the granted channel can be accepted; the counter decrements per flit; when the last flit is accepted the FSM returns to IDLE in the next cycle.
REQ-023 In SEND, when the granted channel has no valid flit or zero credits, noc_ready SHALL be 0 and intf_channel SHALL be 2'b00 that cycle (packet-atomic; no interleaving).
REQ-024 noc_ready SHALL be one-hot or zero, and combinational from state, credits and noc_valid.
REQ-025 An accepted flit SHALL appear on intf_data/intf_channel exactly one cycle later.
REQ-026 Idle cycles SHALL drive intf_channel 2'b00; intf_data holds its last value.
REQ-027 Back-to-back packets SHALL be possible with zero idle cycles between them.

Reset
REQ-028 Under rst: intf_data 0, intf_channel 2'b00, noc_ready 0, credit_err 0, FSM IDLE, credits CREDITS, pointer NoC3, stall_cnt 0.
REQ-029 rst mid-packet SHALL abandon the packet; no flit may be emitted in the cycle after rst is asserted.

Configuration
REQ-030 With CHIP_INTF_ARB_STATS_EN defined, stall_cnt SHALL count cycles where any noc_valid is 1 and no flit is accepted; it saturates at all-ones.
REQ-031 Without CHIP_INTF_ARB_STATS_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 A shared package chip_intf_pkg SHALL hold: channel tag constants (IDLE, NOC1..NOC3), header length field bounds (29, 22), FSM state typedef, channel count (3).
REQ-033 One sub-module, chip_intf_credit_cnt (one counter with saturation and error output), SHALL be instantiated three times.

Verification
REQ-034 After rst, NoC2 sends a header of length 0 with data 0x00000000 -> next cycle intf_channel=2'b10, intf_data=0x00000000; NoC2 credit count = 7.
REQ-035 All three channels are valid with length-1 packets -> header/payload order is NoC1, NoC1, NoC2, NoC2, NoC3, NoC3 with no idle cycles.
REQ-036 NoC1 sends 9 single-flit packets and no credits are returned -> 8 flits are sent, then intf_channel stays 2'b00 while NoC1 is stalled; one intf_credit_back[0] pulse -> the 9th flit leaves one cycle after the credit is visible.
REQ-037 Header length 3 on NoC3 with noc_valid dropping for 2 cycles mid-packet -> 2 idle cycles, no NoC1/NoC2 flits interleaved, and the packet completes.
REQ-038 intf_credit_back[1] pulses while NoC2 is at CREDITS -> credit_err=1 and stays set; simultaneous send and return -> count unchanged.
REQ-039 rst asserted during SEND -> next cycle intf_channel=2'b00 and all reset values hold; with CHIP_INTF_ARB_STATS_EN, stall_cnt equals the number of stalled cycles in REQ-036.
